// File: rtl/if_debug_sequencer.sv
// Debug sequencer: loads instruction memory from UART bytes and runs the pipeline
// in continuous or single-step mode, draining and stopping after a HALT fetch.
module if_debug_sequencer #(
    parameter int              NB         = 32,
    parameter int              TAM_I      = 256,
    parameter logic [NB-1:0]   HALT_INSTR = 32'hFFFF_FFFF,
    parameter int              DRAIN      = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_rx_valid,
    input  logic [7:0]    i_rx_data,
    input  logic [NB-1:0] i_instruction,
    output logic          o_step,
    output logic          o_imem_we,
    output logic [NB-1:0] o_imem_addr,
    output logic [NB-1:0] o_imem_data,
    output logic          o_pipe_clear,
    output logic [2:0]    o_state,
    output logic          o_halted,
    output logic [NB-1:0] o_cycle_count
);

    localparam int DW = (DRAIN > 1) ? $clog2(DRAIN + 1) : 1;

    localparam logic [7:0] CMD_L = 8'h4C;
    localparam logic [7:0] CMD_C = 8'h43;
    localparam logic [7:0] CMD_S = 8'h53;
    localparam logic [7:0] CMD_N = 8'h4E;
    localparam logic [7:0] CMD_R = 8'h52;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READY = 3'd2,
        S_RUN   = 3'd3,
        S_STEP  = 3'd4,
        S_DRAIN = 3'd5,
        S_HALT  = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic          mode_q, mode_d;      // 1: continuous run, 0: single-step
    logic [1:0]    bcnt_q, bcnt_d;
    logic [NB-9:0] asm_q, asm_d;
    logic [NB-1:0] waddr_q, waddr_d;
    logic [DW-1:0] drain_q, drain_d;

    logic          step_q, step_d;
    logic          we_q, we_d;
    logic [NB-1:0] iaddr_q, iaddr_d;
    logic [NB-1:0] idata_q, idata_d;
    logic          clear_q, clear_d;
    logic          halted_q, halted_d;
    logic [NB-1:0] cnt_q, cnt_d;

    logic          rx_l, rx_c, rx_s, rx_n, rx_r;
    logic [NB-1:0] word_w;
    logic          last_word;
    logic          halt_hit;

    assign rx_l      = i_rx_valid && (i_rx_data == CMD_L);
    assign rx_c      = i_rx_valid && (i_rx_data == CMD_C);
    assign rx_s      = i_rx_valid && (i_rx_data == CMD_S);
    assign rx_n      = i_rx_valid && (i_rx_data == CMD_N);
    assign rx_r      = i_rx_valid && (i_rx_data == CMD_R);
    assign word_w    = {asm_q, i_rx_data};
    assign last_word = (waddr_q == NB'(TAM_I - 4));
    assign halt_hit  = step_q && (i_instruction == HALT_INSTR);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            bcnt_q   <= '0;
            asm_q    <= '0;
            waddr_q  <= '0;
            drain_q  <= '0;
            step_q   <= 1'b0;
            we_q     <= 1'b0;
            iaddr_q  <= '0;
            idata_q  <= '0;
            clear_q  <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            bcnt_q   <= bcnt_d;
            asm_q    <= asm_d;
            waddr_q  <= waddr_d;
            drain_q  <= drain_d;
            step_q   <= step_d;
            we_q     <= we_d;
            iaddr_q  <= iaddr_d;
            idata_q  <= idata_d;
            clear_q  <= clear_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        waddr_d = waddr_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (rx_l) begin
                    state_d = S_LOAD;
                    waddr_d = '0;
                    bcnt_d  = '0;
                end
            end
            S_LOAD: begin
                if (i_rx_valid) begin
                    asm_d = {asm_q[NB-17:0], i_rx_data};
                    if (bcnt_q == 2'd3) begin
                        bcnt_d  = '0;
                        waddr_d = waddr_q + NB'(4);
                        if ((word_w == HALT_INSTR) || last_word) begin
                            state_d = S_READY;
                        end
                    end else begin
                        bcnt_d = bcnt_q + 2'd1;
                    end
                end
            end
            S_READY: begin
                if (rx_c) begin
                    state_d = S_RUN;
                    mode_d  = 1'b1;
                end else if (rx_s) begin
                    state_d = S_STEP;
                    mode_d  = 1'b0;
                end else if (rx_l) begin
                    state_d = S_LOAD;
                    waddr_d = '0;
                    bcnt_d  = '0;
                end
            end
            S_RUN, S_STEP: begin
                if (halt_hit) begin
                    drain_d = DW'(DRAIN);
                    state_d = (DRAIN == 0) ? S_HALT : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (step_q) begin
                    drain_d = drain_q - DW'(1);
                    if (drain_q == DW'(1)) begin
                        state_d = S_HALT;
                    end
                end
            end
            S_HALT: begin
                if (rx_r) begin
                    state_d = S_IDLE;
                end else if (rx_l) begin
                    state_d = S_LOAD;
                    waddr_d = '0;
                    bcnt_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed one cycle early from the next state so they can be registered.
    always_comb begin
        step_d = 1'b0;
        if ((state_d == S_RUN) || ((state_d == S_DRAIN) && mode_d)) begin
            step_d = 1'b1;
        end else if (((state_q == S_STEP) || (state_q == S_DRAIN)) && (state_d == state_q)
                     && rx_n && !step_q) begin
            step_d = 1'b1;
        end
        we_d     = (state_q == S_LOAD) && i_rx_valid && (bcnt_q == 2'd3);
        iaddr_d  = we_d ? waddr_q : iaddr_q;
        idata_d  = we_d ? word_w : idata_q;
        clear_d  = ((state_q == S_LOAD) && (state_d == S_READY)) ||
                   ((state_q == S_HALT) && (state_d == S_IDLE));
        halted_d = (state_d == S_HALT);
        cnt_d    = clear_d ? '0 : cnt_q + {{(NB-1){1'b0}}, step_q};
    end

    assign o_step        = step_q;
    assign o_imem_we     = we_q;
    assign o_imem_addr   = iaddr_q;
    assign o_imem_data   = idata_q;
    assign o_pipe_clear  = clear_q;
    assign o_state       = state_q;
    assign o_halted      = halted_q;
    assign o_cycle_count = cnt_q;

endmodule

// File: tb/tb_if_debug_sequencer.sv
// Directed bench for if_debug_sequencer: vector table for load/command decoding,
// hand-written sequences for run, single-step, drain, reset and memory-full cases.
module tb_if_debug_sequencer;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        clr;
        logic [2:0]  st;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [31:0] instr;
    logic        o_step, o_imem_we, o_pipe_clear, o_halted;
    logic [31:0] o_imem_addr, o_imem_data, o_cycle_count;
    logic [2:0]  o_state;

    int n_cmp = 0;
    int n_err = 0;
    int pc = 0;
    int halt_pc = 100000;

    vec_t tbl [13];

    if_debug_sequencer #(
        .NB(32), .TAM_I(256), .HALT_INSTR(32'hFFFF_FFFF), .DRAIN(4)
    ) dut (
        .i_clk(clk), .i_reset(rst_n), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
        .i_instruction(instr), .o_step(o_step), .o_imem_we(o_imem_we),
        .o_imem_addr(o_imem_addr), .o_imem_data(o_imem_data), .o_pipe_clear(o_pipe_clear),
        .o_state(o_state), .o_halted(o_halted), .o_cycle_count(o_cycle_count)
    );

    always #5 clk = ~clk;

    // Fetch model: PC advances on every stepped edge.
    always @(posedge clk) if (o_step) pc <= pc + 1;
    assign instr = (pc == halt_pc) ? HALT : NOP;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    initial begin
        int steps, drains, writes;
        logic [7:0] wb;

        tbl[0]  = '{1'b1, 8'h43, 1'b0, 32'h0, 32'h0,         1'b0, 3'd0};
        tbl[1]  = '{1'b1, 8'h4C, 1'b0, 32'h0, 32'h0,         1'b0, 3'd1};
        tbl[2]  = '{1'b1, 8'h12, 1'b0, 32'h0, 32'h0,         1'b0, 3'd1};
        tbl[3]  = '{1'b1, 8'h34, 1'b0, 32'h0, 32'h0,         1'b0, 3'd1};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 32'h0, 32'h0,         1'b0, 3'd1};
        tbl[5]  = '{1'b1, 8'h56, 1'b0, 32'h0, 32'h0,         1'b0, 3'd1};
        tbl[6]  = '{1'b1, 8'h78, 1'b1, 32'h0, 32'h12345678,  1'b0, 3'd1};
        tbl[7]  = '{1'b1, 8'hFF, 1'b0, 32'h0, 32'h0,         1'b0, 3'd1};
        tbl[8]  = '{1'b1, 8'hFF, 1'b0, 32'h0, 32'h0,         1'b0, 3'd1};
        tbl[9]  = '{1'b1, 8'hFF, 1'b0, 32'h0, 32'h0,         1'b0, 3'd1};
        tbl[10] = '{1'b1, 8'hFF, 1'b1, 32'h4, 32'hFFFFFFFF,  1'b1, 3'd2};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 32'h0, 32'h0,         1'b0, 3'd2};
        tbl[12] = '{1'b1, 8'h4E, 1'b0, 32'h0, 32'h0,         1'b0, 3'd2};

        // Reset held, then released
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(o_state), 0);
        chk("rst_outs", {26'd0, o_step, o_imem_we, o_pipe_clear, o_halted, 2'b0}, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_state", 32'(o_state), 0);
        chk("post_rst_cnt", o_cycle_count, 0);

        // Reset mid-LOAD discards the partial word
        send(8'h4C);
        send(8'h12);
        send(8'h34);
        chk("midload_state", 32'(o_state), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(o_state), 0);
        chk("async_rst_we", 32'(o_imem_we), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h56);
        chk("idle_byte_we", 32'(o_imem_we), 0);
        send(8'h78);
        chk("idle_byte_we2", 32'(o_imem_we), 0);
        chk("idle_byte_state", 32'(o_state), 0);

        // Table: ignored command in IDLE, load of two words ending with HALT
        for (int i = 0; i < 13; i++) begin
            rx_valid = tbl[i].v;
            rx_data  = tbl[i].d;
            tick();
            rx_valid = 1'b0;
            chk($sformatf("tbl%0d_state", i), 32'(o_state), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_we", i), 32'(o_imem_we), 32'(tbl[i].we));
            chk($sformatf("tbl%0d_clr", i), 32'(o_pipe_clear), 32'(tbl[i].clr));
            chk($sformatf("tbl%0d_step", i), 32'(o_step), 0);
            if (tbl[i].we) begin
                chk($sformatf("tbl%0d_addr", i), o_imem_addr, tbl[i].addr);
                chk($sformatf("tbl%0d_data", i), o_imem_data, tbl[i].data);
            end
        end

        // Continuous run, HALT is the third fetched instruction
        halt_pc = pc + 2;
        send(8'h43);
        steps  = 0;
        drains = 0;
        for (int k = 0; k < 40 && !o_halted; k++) begin
            if (o_step) steps++;
            if (o_state == 3'd5) drains++;
            tick();
        end
        chk("run_steps", 32'(steps), 7);
        chk("run_drain_cycles", 32'(drains), 4);
        chk("run_halted", 32'(o_halted), 1);
        chk("run_state", 32'(o_state), 6);
        chk("run_cnt", o_cycle_count, 7);
        chk("run_step_off", 32'(o_step), 0);

        // HALT: 'C' ignored, 'R' clears, 'C' in IDLE ignored
        send(8'h43);
        chk("halt_c_state", 32'(o_state), 6);
        send(8'h52);
        chk("r_clr", 32'(o_pipe_clear), 1);
        chk("r_cnt", o_cycle_count, 0);
        chk("r_state", 32'(o_state), 0);
        chk("r_halted", 32'(o_halted), 0);
        tick();
        chk("r_clr_pulse", 32'(o_pipe_clear), 0);
        send(8'h43);
        chk("idle_c_state", 32'(o_state), 0);
        chk("idle_c_step", 32'(o_step), 0);

        // Single-step mode
        halt_pc = 100000;
        send(8'h4C);
        repeat (3) send(8'hFF);
        send(8'hFF);
        chk("sl_we", 32'(o_imem_we), 1);
        chk("sl_addr", o_imem_addr, 0);
        chk("sl_state", 32'(o_state), 2);
        send(8'h53);
        chk("s_state", 32'(o_state), 4);
        chk("s_step", 32'(o_step), 0);
        for (int k = 0; k < 3; k++) begin
            send(8'h4E);
            chk($sformatf("n%0d_pulse", k), 32'(o_step), 1);
            tick();
            chk($sformatf("n%0d_end", k), 32'(o_step), 0);
        end
        chk("n_cnt3", o_cycle_count, 3);
        send(8'h4E);
        chk("bb_first", 32'(o_step), 1);
        send(8'h4E);
        chk("bb_second_ignored", 32'(o_step), 0);
        tick();
        chk("bb_idle", 32'(o_step), 0);
        chk("bb_cnt", o_cycle_count, 4);

        // HALT fetched on a stepped cycle, then drained by four more 'N'
        halt_pc = pc;
        send(8'h4E);
        chk("sh_pulse", 32'(o_step), 1);
        tick();
        chk("sh_state", 32'(o_state), 5);
        chk("sh_step", 32'(o_step), 0);
        chk("sh_cnt", o_cycle_count, 5);
        for (int k = 0; k < 4; k++) begin
            send(8'h4E);
            chk($sformatf("sd%0d_pulse", k), 32'(o_step), 1);
            tick();
            chk($sformatf("sd%0d_state", k), 32'(o_state), (k == 3) ? 6 : 5);
        end
        chk("sd_cnt", o_cycle_count, 9);
        chk("sd_halted", 32'(o_halted), 1);

        // Reload from HALT keeps the count until the memory is full
        send(8'h4C);
        chk("hl_state", 32'(o_state), 1);
        chk("hl_cnt", o_cycle_count, 9);
        writes = 0;
        for (int w = 0; w < 64; w++) begin
            wb = 8'(w);
            send(8'hA0);
            send(8'h00);
            send(8'h00);
            send(wb);
            if (o_imem_we) writes++;
            chk($sformatf("w%0d_addr", w), o_imem_addr, 32'(4 * w));
            chk($sformatf("w%0d_data", w), o_imem_data, {24'hA00000, wb});
            chk($sformatf("w%0d_state", w), 32'(o_state), (w == 63) ? 2 : 1);
        end
        chk("full_writes", 32'(writes), 64);
        chk("full_clr", 32'(o_pipe_clear), 1);
        chk("full_cnt", o_cycle_count, 0);
        writes = 0;
        send(8'h11); if (o_imem_we) writes++;
        send(8'h22); if (o_imem_we) writes++;
        send(8'h33); if (o_imem_we) writes++;
        send(8'h44); if (o_imem_we) writes++;
        tick();
        if (o_imem_we) writes++;
        chk("extra_writes", 32'(writes), 0);
        chk("extra_state", 32'(o_state), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
